uart_msg_transmitter: RTL and testbench
=======================================

Name: uart_msg_transmitter

Overview:
Parametrised successor to the fixed "Hello World!" string sender. It transmits a run-time-loaded message buffer over a UART line. The UART framer is integrated, and data width, parity, stop bits, baud divider and buffer depth are all configurable. A repeat mode re-sends the message continuously until stopped. The block sits between a host or control FSM and the board TX pin.

Parameters:
CLKS_PER_BIT, 868, clock cycles per UART bit (>=2)
DATA_BITS, 8, data bits per character (5..8), LSB first
PARITY, 0, 0 = none, 1 = odd, 2 = even
STOP_BITS, 1, number of stop bits (1 or 2)
DEPTH, 16, message buffer entries (power of 2, >=2); AW = $clog2(DEPTH)

Ports:
clock  in  1  system clock
reset_n  in  1  asynchronous, active-low reset
wr_en  in  1  buffer write strobe; honoured only when busy=0
wr_addr  in  AW  buffer write address
wr_data  in  DATA_BITS  buffer write data
len  in  AW+1  message length in characters; sampled on accepted start
start  in  1  start request; level-sampled, accepted only in IDLE
repeat_en  in  1  sampled on accepted start; 1 = loop the message until stop
stop  in  1  request graceful stop; sampled while busy
tx  out  1  UART line; idles high
busy  out  1  high from accepted start until the message completes
done  out  1  one-cycle pulse when the message (or a stopped loop) finishes
char_idx  out  AW  index of the character currently being framed

Behaviour:
- Reset (async assert, sync deassert is the integrator's responsibility):
  - tx=1, busy=0, done=0, char_idx=0, FSM=IDLE, stop latch cleared.
  - Buffer contents are NOT cleared.
- FSM states: IDLE, START_B, DATA_B, PARITY_B, STOP_B.
  - Each non-IDLE state holds for CLKS_PER_BIT cycles per bit, timed by the baud counter.
  - DATA_B counts DATA_BITS bits; STOP_B counts STOP_BITS bits.
  - PARITY_B is skipped when PARITY=0.
- Frame length F = 1 + DATA_BITS + (PARITY!=0) + STOP_BITS bits.
- Start acceptance: start=1 in IDLE with 1 <= len <= DEPTH.
  - On that edge: busy=1, char_idx=0, buffer[0] is loaded into the shift register, and repeat_en and len are latched.
  - tx drops low on the same edge, giving 1 cycle of latency from the sampled start.
  - start with len=0 or len>DEPTH is ignored: no busy, no done.
- Characters go back to back, with no idle gap between frames.
  - At the end of the last stop bit of character i: if i+1 < len_latched, char_idx becomes i+1, buffer[i+1] is loaded and START_B is entered.
- End of message, when the last character's last stop bit ends:
  - repeat off, or stop latched: FSM=IDLE, busy=0, done=1 for exactly one cycle, tx=1.
  - repeat on and stop not latched: char_idx wraps to 0 and transmission continues seamlessly.
- stop: any cycle with busy=1 and stop=1 sets the stop latch.
  - In repeat mode the current pass completes through the last character, then the block ends as above.
  - In single-shot mode the message completes normally.
  - The latch clears on entry to IDLE. stop in IDLE has no effect.
- Parity bit: odd gives XOR(data)^1; even gives XOR(data).
- Buffer writes:
  - Write is accepted when wr_en=1 and busy=0; there is no write when busy=1.
  - A write on the same edge as an accepted start is stored, but character 0 is sent with the pre-write value.
- start held high continuously: a new message begins the cycle after done (IDLE for 1 cycle, then restart).
- Total busy time for a single-shot message = len*F*CLKS_PER_BIT cycles.
- Async reset mid-frame: tx returns high immediately and no done pulse is generated.

Test Plan:
- CLKS_PER_BIT=4, 8N1, write "Hi" (0x48,0x69), len=2, start pulse -> tx waveform 0,00010010,1,0,10010110,1 with each bit 4 cycles wide; busy high for 80 cycles; done a single pulse at cycle 81.
- PARITY=2 (even), DATA_BITS=7, send 0x41 -> parity bit 0; with PARITY=1, same data -> parity bit 1; frame length 10 bits.
- repeat_en=1, len=3, assert stop during char_idx=1 of pass 2 -> pass 2 finishes char 2 then done; char_idx sequence 0,1,2,0,1,2; no third pass.
- Start with len=0 and with len=DEPTH+1 -> busy stays 0, tx stays 1, no done; a write with wr_en while busy -> buffer unchanged (verified by resending).
- Drop reset_n mid DATA_B bit 3 -> tx=1, busy=0 within the same cycle, no done; after release, start len=1 sends the buffer contents intact.
- STOP_BITS=2, start held high, len=1 -> back-to-back messages with exactly one idle-high cycle plus two stop bits between frames; done pulses every F*CLKS_PER_BIT+1 cycles.

Source files
------------

// File: rtl/uart_msg_transmitter.sv
`default_nettype none
// ============================================================================
// Module   : uart_msg_transmitter
// Purpose  : Sends a run-time loaded message buffer over a UART line. The
//            framer is built in. Data width, parity, stop bits, baud divider
//            and buffer depth are all parameters. An optional repeat mode
//            loops the message until a graceful stop is requested.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   clock      in   1          system clock
//   reset_n    in   1          asynchronous active-low reset
//   wr_en      in   1          buffer write strobe (ignored while busy)
//   wr_addr    in   AW         buffer write address
//   wr_data    in   DATA_BITS  buffer write data
//   len        in   AW+1       message length, sampled on accepted start
//   start      in   1          start request, accepted only when idle
//   repeat_en  in   1          loop mode, sampled on accepted start
//   stop       in   1          graceful stop request while busy
//   tx         out  1          UART line, idles high
//   busy       out  1          message in progress
//   done       out  1          one-cycle end-of-message pulse
//   char_idx   out  AW         index of the character being framed
// ============================================================================
module uart_msg_transmitter #(
  parameter int CLKS_PER_BIT = 868,
  parameter int DATA_BITS    = 8,
  parameter int PARITY       = 0,
  parameter int STOP_BITS    = 1,
  parameter int DEPTH        = 16,
  localparam int AW          = $clog2(DEPTH)
) (
  input  logic                 clock,
  input  logic                 reset_n,
  input  logic                 wr_en,
  input  logic [AW-1:0]        wr_addr,
  input  logic [DATA_BITS-1:0] wr_data,
  input  logic [AW:0]          len,
  input  logic                 start,
  input  logic                 repeat_en,
  input  logic                 stop,
  output logic                 tx,
  output logic                 busy,
  output logic                 done,
  output logic [AW-1:0]        char_idx
);

  localparam int             BAUD_W     = $clog2(CLKS_PER_BIT);
  localparam int             CNT_W      = 3;
  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0]  DATA_LAST = CNT_W'(DATA_BITS - 1);
  localparam logic [CNT_W-1:0]  STOP_LAST = CNT_W'(STOP_BITS - 1);
  localparam logic [AW:0]       DEPTH_L   = (AW + 1)'(DEPTH);
  localparam logic              PAR_ODD   = (PARITY == 1);
  localparam logic              HAS_PAR   = (PARITY != 0);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_START_B  = 3'd1,
    S_DATA_B   = 3'd2,
    S_PARITY_B = 3'd3,
    S_STOP_B   = 3'd4
  } state_t;

  // --------------------------------------------------------------------------
  // Message buffer: no reset so contents survive a reset of the framer.
  // --------------------------------------------------------------------------
  logic [DATA_BITS-1:0] mem_q [DEPTH];

  logic busy_q, busy_d;

  always_ff @(posedge clock) begin
    if (wr_en && !busy_q) begin
      mem_q[wr_addr] <= wr_data;
    end
  end

  // --------------------------------------------------------------------------
  // Framer state
  // --------------------------------------------------------------------------
  state_t               state_q,    state_d;
  logic [BAUD_W-1:0]    baud_q,     baud_d;
  logic [CNT_W-1:0]     bit_cnt_q,  bit_cnt_d;
  logic [DATA_BITS-1:0] shift_q,    shift_d;
  logic                 parity_q,   parity_d;
  logic [AW-1:0]        char_idx_q, char_idx_d;
  logic [AW:0]          len_q,      len_d;
  logic                 repeat_q,   repeat_d;
  logic                 stop_q,     stop_d;
  logic                 tx_q,       tx_d;
  logic                 done_q,     done_d;

  // Character loader: selects which buffer entry feeds the shift register.
  logic                 load_en;
  logic [AW-1:0]        load_idx;
  logic [DATA_BITS-1:0] load_data;

  logic                 bit_end;
  logic                 more_chars;
  logic                 stop_seen;
  logic [AW-1:0]        next_idx;

  assign load_data  = mem_q[load_idx];
  assign bit_end    = (baud_q == BAUD_LAST);
  assign next_idx   = char_idx_q + AW'(1);
  // Widened compare so that len_q == DEPTH works at the last index.
  assign more_chars = (({1'b0, char_idx_q}) + (AW + 1)'(1)) < len_q;
  // A stop raised in the final cycle of a pass still ends the loop.
  assign stop_seen  = stop_q | stop;

  always_comb begin
    state_d    = state_q;
    baud_d     = baud_q;
    bit_cnt_d  = bit_cnt_q;
    shift_d    = shift_q;
    parity_d   = parity_q;
    char_idx_d = char_idx_q;
    len_d      = len_q;
    repeat_d   = repeat_q;
    stop_d     = stop_q;
    tx_d       = tx_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    load_en    = 1'b0;
    load_idx   = '0;

    if (state_q == S_IDLE) begin
      tx_d = 1'b1;
      if (start && (len != '0) && (len <= DEPTH_L)) begin
        state_d    = S_START_B;
        busy_d     = 1'b1;
        char_idx_d = '0;
        len_d      = len;
        repeat_d   = repeat_en;
        stop_d     = 1'b0;
        baud_d     = '0;
        tx_d       = 1'b0;
        load_en    = 1'b1;
        load_idx   = '0;
      end
    end else begin
      stop_d = stop_seen;
      baud_d = bit_end ? '0 : baud_q + BAUD_W'(1);

      case (state_q)
        S_START_B: begin
          if (bit_end) begin
            state_d   = S_DATA_B;
            bit_cnt_d = '0;
            tx_d      = shift_q[0];
          end
        end

        S_DATA_B: begin
          if (bit_end) begin
            if (bit_cnt_q == DATA_LAST) begin
              bit_cnt_d = '0;
              if (HAS_PAR) begin
                state_d = S_PARITY_B;
                tx_d    = parity_q;
              end else begin
                state_d = S_STOP_B;
                tx_d    = 1'b1;
              end
            end else begin
              bit_cnt_d = bit_cnt_q + CNT_W'(1);
              shift_d   = shift_q >> 1;
              tx_d      = shift_q[1];
            end
          end
        end

        S_PARITY_B: begin
          if (bit_end) begin
            state_d   = S_STOP_B;
            bit_cnt_d = '0;
            tx_d      = 1'b1;
          end
        end

        S_STOP_B: begin
          if (bit_end) begin
            if (bit_cnt_q == STOP_LAST) begin
              if (more_chars) begin
                // Next character follows with no idle gap.
                state_d    = S_START_B;
                char_idx_d = next_idx;
                load_en    = 1'b1;
                load_idx   = next_idx;
                tx_d       = 1'b0;
              end else if (repeat_q && !stop_seen) begin
                state_d    = S_START_B;
                char_idx_d = '0;
                load_en    = 1'b1;
                load_idx   = '0;
                tx_d       = 1'b0;
              end else begin
                state_d    = S_IDLE;
                busy_d     = 1'b0;
                done_d     = 1'b1;
                stop_d     = 1'b0;
                char_idx_d = '0;
                tx_d       = 1'b1;
              end
            end else begin
              bit_cnt_d = bit_cnt_q + CNT_W'(1);
              tx_d      = 1'b1;
            end
          end
        end

        default: begin
          state_d = S_IDLE;
          busy_d  = 1'b0;
          stop_d  = 1'b0;
          tx_d    = 1'b1;
        end
      endcase
    end

    // Parity is computed once per character, from the unshifted value.
    if (load_en) begin
      shift_d  = load_data;
      parity_d = (^load_data) ^ PAR_ODD;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= S_IDLE;
      baud_q     <= '0;
      bit_cnt_q  <= '0;
      shift_q    <= '0;
      parity_q   <= 1'b0;
      char_idx_q <= '0;
      len_q      <= '0;
      repeat_q   <= 1'b0;
      stop_q     <= 1'b0;
      tx_q       <= 1'b1;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      baud_q     <= baud_d;
      bit_cnt_q  <= bit_cnt_d;
      shift_q    <= shift_d;
      parity_q   <= parity_d;
      char_idx_q <= char_idx_d;
      len_q      <= len_d;
      repeat_q   <= repeat_d;
      stop_q     <= stop_d;
      tx_q       <= tx_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  assign tx       = tx_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign char_idx = char_idx_q;

endmodule
`default_nettype wire

// File: tb/tb_uart_msg_transmitter.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_msg_transmitter
// Purpose  : Self-checking bench for uart_msg_transmitter. A line receiver
//            decodes every frame on tx and compares it with frames queued by
//            the stimulus from a behavioural model of the message buffer.
// Revision : 1.0 - initial release
// ============================================================================
module tb_uart_msg_transmitter;

  localparam int C     = 4;
  localparam int DB    = 7;
  localparam int PAR   = 1;
  localparam int SB    = 2;
  localparam int DEPTH = 4;
  localparam int AW    = 2;
  localparam int F     = 1 + DB + ((PAR != 0) ? 1 : 0) + SB;
  localparam int FC    = F * C;

  logic          clock = 1'b0;
  logic          reset_n = 1'b0;
  logic          wr_en = 1'b0;
  logic [AW-1:0] wr_addr = '0;
  logic [DB-1:0] wr_data = '0;
  logic [AW:0]   len = '0;
  logic          start = 1'b0;
  logic          repeat_en = 1'b0;
  logic          stop = 1'b0;
  logic          tx;
  logic          busy;
  logic          done;
  logic [AW-1:0] char_idx;

  uart_msg_transmitter #(
    .CLKS_PER_BIT(C),
    .DATA_BITS   (DB),
    .PARITY      (PAR),
    .STOP_BITS   (SB),
    .DEPTH       (DEPTH)
  ) dut (
    .clock    (clock),
    .reset_n  (reset_n),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .len      (len),
    .start    (start),
    .repeat_en(repeat_en),
    .stop     (stop),
    .tx       (tx),
    .busy     (busy),
    .done     (done),
    .char_idx (char_idx)
  );

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  typedef struct {
    logic [F-1:0] bits;
    int           idx;
  } exp_t;

  exp_t          exp_q[$];
  logic [DB-1:0] model_mem [DEPTH];
  int            checks = 0;
  int            errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Expected line bits of one character, bit 0 first on the wire.
  function automatic logic [F-1:0] frame_of(input logic [DB-1:0] d);
    logic [F-1:0] f;
    int ones;
    f = '1;
    f[0] = 1'b0;
    ones = 0;
    for (int i = 0; i < DB; i++) begin
      f[1 + i] = d[i];
      if (d[i]) ones++;
    end
    if (PAR == 1) f[1 + DB] = (ones % 2 == 0);
    if (PAR == 2) f[1 + DB] = (ones % 2 == 1);
    return f;
  endfunction

  task automatic push_msg(input int l);
    exp_t e;
    for (int i = 0; i < l; i++) begin
      e.bits = frame_of(model_mem[i]);
      e.idx  = i;
      exp_q.push_back(e);
    end
  endtask

  // --------------------------------------------------------------------------
  // Line receiver / scoreboard checker
  // --------------------------------------------------------------------------
  initial begin : monitor
    logic [F-1:0] got;
    int           idx;
    int           n;
    bit           ab;
    exp_t         e;
    forever begin
      @(negedge clock);
      if (reset_n && busy && (tx == 1'b0)) begin
        ab  = 1'b0;
        idx = int'(char_idx);
        got = '0;
        for (int b = 0; b < F; b++) begin
          n = (b == 0) ? C / 2 : C;
          repeat (n) begin
            @(negedge clock);
            if (!reset_n) ab = 1'b1;
          end
          if (ab) break;
          got[b] = tx;
        end
        if (!ab) begin
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_frame: got %b expected none", got);
          end else begin
            e = exp_q.pop_front();
            check("frame_bits", 64'(got), 64'(e.bits));
            check("char_idx", 64'(idx), 64'(e.idx));
          end
        end
      end
    end
  end

  // --------------------------------------------------------------------------
  // Stimulus helpers
  // --------------------------------------------------------------------------
  task automatic write_mem(input int a, input logic [DB-1:0] d);
    @(negedge clock);
    wr_en   = 1'b1;
    wr_addr = AW'(a);
    wr_data = d;
    @(negedge clock);
    wr_en   = 1'b0;
    model_mem[a] = d;
  endtask

  task automatic start_msg(input int l, input bit rep);
    @(negedge clock);
    start     = 1'b1;
    len       = (AW + 1)'(l);
    repeat_en = rep;
    @(negedge clock);
    start     = 1'b0;
    check("accept_busy", 64'(busy), 64'(1));
    check("accept_tx_low", 64'(tx), 64'(0));
  endtask

  // Entered on the first busy negedge; counts busy cycles until done.
  task automatic wait_done(input int exp_cycles);
    int cnt;
    int guard;
    cnt   = 1;
    guard = 0;
    while (guard < exp_cycles * 2 + 100) begin
      @(negedge clock);
      guard++;
      if (busy !== 1'b1) break;
      cnt++;
    end
    check("busy_cycles", 64'(cnt), 64'(exp_cycles));
    check("done_pulse", 64'(done), 64'(1));
    @(negedge clock);
    check("done_width", 64'(done), 64'(0));
  endtask

  task automatic wait_idx(input int v);
    for (int g = 0; g < 2000; g++) begin
      @(negedge clock);
      if (int'(char_idx) == v) break;
    end
  endtask

  initial begin : watchdog
    #400000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  // --------------------------------------------------------------------------
  // Main sequence
  // --------------------------------------------------------------------------
  initial begin : main
    int            l;
    logic [DB-1:0] v1;
    bit            s_busy, s_txl, s_done;
    int            t[3];

    repeat (3) @(negedge clock);
    check("rst_tx", 64'(tx), 64'(1));
    check("rst_busy", 64'(busy), 64'(0));
    check("rst_done", 64'(done), 64'(0));
    check("rst_char_idx", 64'(char_idx), 64'(0));
    reset_n = 1'b1;

    // Random single-shot messages, first one at full depth.
    for (int it = 0; it < 5; it++) begin
      for (int a = 0; a < DEPTH; a++) write_mem(a, DB'($urandom));
      l = (it == 0) ? DEPTH : int'($urandom_range(1, DEPTH));
      push_msg(l);
      start_msg(l, 1'b0);
      wait_done(l * FC);
    end

    // Out-of-range lengths are ignored.
    for (int k = 0; k < 2; k++) begin
      @(negedge clock);
      start = 1'b1;
      len   = (k == 0) ? '0 : (AW + 1)'(DEPTH + 1);
      @(negedge clock);
      start = 1'b0;
      s_busy = 0; s_txl = 0; s_done = 0;
      repeat (20) begin
        if (busy) s_busy = 1;
        if (!tx) s_txl = 1;
        if (done) s_done = 1;
        @(negedge clock);
      end
      check("ignored_busy", 64'(s_busy), 64'(0));
      check("ignored_tx", 64'(s_txl), 64'(0));
      check("ignored_done", 64'(s_done), 64'(0));
    end

    // Write on the accept edge is stored but char 0 uses the old value;
    // a write while busy is dropped.
    v1 = DB'($urandom);
    push_msg(1);
    @(negedge clock);
    start = 1'b1; len = 1; repeat_en = 1'b0;
    wr_en = 1'b1; wr_addr = '0; wr_data = v1;
    @(negedge clock);
    start = 1'b0; wr_en = 1'b0;
    model_mem[0] = v1;
    check("accept_busy", 64'(busy), 64'(1));
    fork
      wait_done(FC);
      begin
        @(negedge clock);
        wr_en = 1'b1; wr_addr = '0; wr_data = ~v1;
        @(negedge clock);
        wr_en = 1'b0;
      end
    join
    push_msg(1);
    start_msg(1, 1'b0);
    wait_done(FC);

    // Repeat mode: stop during pass 2, char 1 -> pass 2 completes, no pass 3.
    for (int a = 0; a < 3; a++) write_mem(a, DB'($urandom));
    push_msg(3);
    push_msg(3);
    start_msg(3, 1'b1);
    fork
      wait_done(2 * 3 * FC);
      begin
        wait_idx(2);
        wait_idx(0);
        wait_idx(1);
        stop = 1'b1;
        @(negedge clock);
        stop = 1'b0;
      end
    join

    // Async reset in the middle of data bit 3 (which is 0 on the line).
    write_mem(0, DB'($urandom) & ~DB'(8));
    start_msg(2, 1'b0);
    repeat (17) @(negedge clock);
    reset_n = 1'b0;
    #1;
    check("midreset_tx", 64'(tx), 64'(1));
    check("midreset_busy", 64'(busy), 64'(0));
    s_done = 0;
    repeat (3) begin
      @(negedge clock);
      if (done) s_done = 1;
    end
    check("midreset_no_done", 64'(s_done), 64'(0));
    reset_n = 1'b1;
    push_msg(1);
    start_msg(1, 1'b0);
    wait_done(FC);

    // start held high: back-to-back messages separated by one idle cycle.
    push_msg(1);
    push_msg(1);
    push_msg(1);
    @(negedge clock);
    start = 1'b1; len = 1; repeat_en = 1'b0;
    for (int k = 0; k < 3; k++) begin
      t[k] = -1;
      for (int g = 0; g < 4 * FC; g++) begin
        @(negedge clock);
        if (done) begin
          t[k] = cyc;
          break;
        end
      end
    end
    start = 1'b0;
    check("held_interval_1", 64'(t[1] - t[0]), 64'(FC + 1));
    check("held_interval_2", 64'(t[2] - t[1]), 64'(FC + 1));
    repeat (4) @(negedge clock);
    check("held_stopped", 64'(busy), 64'(0));

    for (int g = 0; g < 200 && exp_q.size() != 0; g++) @(negedge clock);
    check("queue_empty", 64'(exp_q.size()), 64'(0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
